popcount10_weight_gen: RTL and testbench
========================================

Name: popcount10_weight_gen

Overview:
Sequential exhaustive stimulus generator, the inverse direction of the popcount10 approximate counters. It takes a target Hamming weight k and emits every 10-bit vector with exactly k ones, one per handshake, in ascending numeric (colex) order. It feeds the popcount10 evaluation harness, so per-weight-class error (MAE/WCE/EP) can be measured on hardware or in printed-PDK emulation.

Parameters:
N, 10, vector width (number of popcount inputs)
KW, 4, weight input width; must satisfy 2^KW > N
IW, 8, output index width; must hold C(N, N/2)-1 (251 for N=10)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
start  in  1  request enumeration; sampled only in IDLE
weight  in  KW  target number of ones k, sampled with start
busy  out  1  high in RUN and DONE
out_valid  out  1  out_vec/out_index/out_last valid
out_ready  in  1  consumer accepts current vector
out_vec  out  N  current vector (input_a of the DUT)
out_index  out  IW  ordinal of out_vec within the weight class, from 0
out_last  out  1  out_vec is the final vector of the class
done  out  1  one-cycle pulse after the last vector is accepted
err  out  1  one-cycle pulse when weight > N

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. All outputs are 0: busy, out_valid, out_vec, out_index, out_last, done, err. Reset overrides every other event, including mid-enumeration; no partial done is produced.
- States: IDLE, RUN, DONE.
- IDLE with start=1 and weight<=N: load out_vec=(1<<k)-1, out_index=0, out_last=(out_vec==((1<<k)-1)<<(N-k)). Go to RUN. out_valid=1 in the next cycle, so latency is 1 cycle from start.
- IDLE with start=1 and weight>N: err=1 for exactly one cycle. Stay in IDLE. No valid is produced.
- start is ignored outside IDLE.
- RUN, handshake = out_valid & out_ready:
  - No handshake: out_vec, out_index and out_last are held stable.
  - Handshake with out_last=0: advance to the next combination in the same cycle and increment out_index. out_valid stays 1, so there is no bubble.
  - Handshake with out_last=1: out_valid drops to 0 and the state goes to DONE.
- DONE: done=1 for one cycle. Then go to IDLE with busy=0. A start in the DONE cycle is ignored.
- Next-combination rule, combinational and divider-free:
  - p = position of the lowest set bit of v.
  - L = length of the run of ones starting at p.
  - next = v with bits p..p+L-1 cleared, bit p+L set, and bits 0..L-2 set.
  - Example: 0x01F -> 0x02F, then 0x037.
- out_last is recomputed for each loaded vector. It is true iff v equals the top-aligned pattern ((1<<k)-1)<<(N-k).
- Special cases:
  - k=0: a single vector 0x000 with out_last=1.
  - k=N: a single vector 0x3FF with out_last=1.
- The number of vectors emitted is exactly C(N,k). out_index never wraps; its final value is C(N,k)-1.
- out_vec is registered; no combinational path exists from out_ready to out_vec.

Test Plan:
1. weight=0, out_ready=1 -> one vector 0x000, idx 0, out_last=1. done pulses on the cycle after the handshake, then busy=0.
2. weight=1, out_ready=1 -> 10 back-to-back vectors 0x001, 0x002, ..., 0x200. idx runs 0..9, and out_last is set only on 0x200.
3. weight=5, out_ready=1 -> 252 vectors: first 0x01F, second 0x02F, last 0x3E0 with idx 251. All vectors are distinct, strictly increasing, and have popcount 5.
4. weight=10 -> single vector 0x3FF with out_last=1. weight=11 -> err pulses for 1 cycle, with out_valid=0 and busy=0 throughout.
5. weight=2 with out_ready toggled pseudo-randomly -> out_vec is held while ready=0, and the sequence is 0x003, 0x005, 0x006, 0x009, ... for 45 vectors. A start pulse asserted mid-run does not change the sequence.
6. rst_n=0 for 1 cycle in the middle of weight=4 enumeration -> all outputs are 0 on the next edge and the state is IDLE. A new start with weight=3 then restarts from 0x007 with idx 0.

Source files
------------

// File: rtl/popcount10_weight_gen.sv
// Exhaustive fixed-weight vector generator: emits every N-bit vector with exactly k ones,
// in ascending numeric order, one per valid/ready handshake.
`timescale 1ns/1ps

module popcount10_weight_gen #(
  parameter int N  = 10,
  parameter int KW = 4,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] weight,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_vec,
  output logic [IW-1:0] out_index,
  output logic          out_last,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int PW = $clog2(N);

  state_t         state_q, state_d;
  logic [N-1:0]   top_q;
  logic [N-1:0]   low_mask, top_mask;
  logic [N-1:0]   lowest, ripple, run_bits, next_vec;
  logic [PW-1:0]  low_pos;
  logic           weight_ok;

  assign weight_ok = int'(weight) <= N;

  // First vector of the class is k ones bottom-aligned; the last one is the same run top-aligned.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    low_mask = '0;
    top_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (i < int'(weight))      low_mask[i] = 1'b1;
      if (i >= N - int'(weight)) top_mask[i] = 1'b1;
    end
  end

  // Successor: adding the lowest set bit clears the lowest run and sets the bit above it;
  // the run's remaining L-1 ones are then re-packed at bit 0.
  always_comb begin
    lowest  = out_vec & (~out_vec + N'(1));
    ripple  = out_vec + lowest;
    run_bits = out_vec ^ ripple;
    low_pos = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (out_vec[i]) low_pos = PW'(i);
    end
    next_vec = ripple | ((run_bits >> 2) >> low_pos);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && weight_ok)   state_d = RUN;
      RUN:     if (out_ready && out_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state_q)
      RUN:  begin busy = 1'b1; out_valid = 1'b1; end
      DONE: begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vec   <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      top_q     <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (weight_ok) begin
              out_vec   <= low_mask;
              out_index <= '0;
              out_last  <= (low_mask == top_mask);
              top_q     <= top_mask;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          // In RUN out_valid is always high, so out_ready alone marks a handshake.
          if (out_ready && !out_last) begin
            out_vec   <= next_vec;
            out_index <= out_index + IW'(1);
            out_last  <= (next_vec == top_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount10_weight_gen.sv
// Randomized bench for popcount10_weight_gen against a reference list of all
// weight-k vectors obtained by scanning 0..2^N-1 in ascending order.
`timescale 1ns/1ps

module tb_popcount10_weight_gen;

  localparam int N  = 10;
  localparam int KW = 4;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [KW-1:0] weight;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_vec;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  popcount10_weight_gen #(.N(N), .KW(KW), .IW(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .weight    (weight),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_index (out_index),
    .out_last  (out_last),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: every vector with popcount k, in ascending numeric order.
  function automatic void build_expected(input int k);
    exp_q.delete();
    for (int v = 0; v < (1 << N); v++)
      if ($countones(v) == k) exp_q.push_back(v);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy),      0);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_vec"},   32'(out_vec),   0);
    check({tag, "_index"}, 32'(out_index), 0);
    check({tag, "_last"},  32'(out_last),  0);
    check({tag, "_done"},  32'(done),      0);
    check({tag, "_err"},   32'(err),       0);
  endtask

  // Enumerate weight k; stop early after max_hs handshakes (left in RUN for the caller).
  task automatic run_class(input int k, input int ready_pct, input bit mid_start, input int max_hs);
    int n;
    int cyc;
    bit fin;
    @(negedge clk);
    start  = 1'b1;
    weight = KW'(k);
    @(negedge clk);
    start = 1'b0;
    build_expected(k);
    n = 0; cyc = 0; fin = 0;
    while (!fin && cyc < 4000) begin
      check("valid_in_run", 32'(out_valid), 1);
      check("busy_in_run",  32'(busy), 1);
      check($sformatf("vec_k%0d", k),   32'(out_vec),   32'(exp_q[n]));
      check($sformatf("index_k%0d", k), 32'(out_index), 32'(n));
      check($sformatf("last_k%0d", k),  32'(out_last),  32'(n == exp_q.size() - 1));
      out_ready = ($urandom_range(99) < 32'(ready_pct));
      start     = mid_start ? 1'($urandom_range(1)) : 1'b0;
      weight    = KW'($urandom_range(15));
      if (out_valid && out_ready) n++;
      if (n == exp_q.size() || n == max_hs) fin = 1;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    start     = 1'b0;
    weight    = '0;
    if (!fin) check("handshake_timeout", 0, 1);
    if (fin && n == exp_q.size()) begin
      check("done_pulse",     32'(done),      1);
      check("done_valid_low", 32'(out_valid), 0);
      check("done_busy",      32'(busy),      1);
      @(negedge clk);
      check("after_done_pulse", 32'(done), 0);
      check("after_done_busy",  32'(busy), 0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    weight    = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    run_class(0, 100, 0, 9999);
    run_class(1, 100, 0, 9999);
    run_class(5, 100, 0, 9999);
    run_class(10, 100, 0, 9999);

    // Out-of-range weight: single err pulse, no enumeration.
    @(negedge clk);
    start  = 1'b1;
    weight = KW'(11);
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", 32'(err),       1);
    check("err_valid", 32'(out_valid), 0);
    check("err_busy",  32'(busy),      0);
    @(negedge clk);
    check("err_clear",       32'(err),       0);
    check("err_valid_after", 32'(out_valid), 0);
    check("err_busy_after",  32'(busy),      0);

    run_class(2, 50, 1, 9999);

    // Reset in the middle of a weight-4 run, then a clean restart.
    run_class(4, 60, 0, 20);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'(busy), 0);
    run_class(3, 100, 0, 9999);

    repeat (6) run_class(int'($urandom_range(10)), int'($urandom_range(30, 100)), 1'b1, 9999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
